// File: rtl/dct_coef_serializer.sv
// dct_coef_serializer
//   Parallel-to-serial converter for DCT coefficient blocks. A whole block of
//   N_COEF coefficients is captured in one handshake into one of two banks
//   (ping-pong). The coefficients are then streamed out one per cycle in
//   index order toward the RLE encoder. The other bank can be filled while
//   one bank streams, so back-to-back blocks leave no bubbles.
//
//   Optional feature macro: DCT_SER_TRUNC_ZEROS_EN
//     When defined, each bank also records the highest nonzero index seen at
//     capture. Streaming stops after that index, so the trailing-zero run is
//     never sent. Coefficient 0 is always sent.
//     When undefined, every block emits exactly N_COEF coefficients.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   block handshake; in_ready depends on registered state only
//   in_data               packed block, coefficient k at [k*DATA_W +: DATA_W]
//   out_valid / out_ready coefficient handshake
//   out_data              current coefficient (0 while idle)
//   out_index             position of out_data within its block
//   out_last              out_data is the final coefficient of the block

// One storage bank: coefficient storage, full flag and, optionally, the
// highest nonzero index of the stored block.
module dct_coef_bank #(
    parameter int DATA_W = 12,
    parameter int N_COEF = 8,
    parameter int IDX_W  = $clog2(N_COEF)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr_en,
    input  logic                           rel,
    input  logic [N_COEF-1:0][DATA_W-1:0]  wr_data,
    output logic                           full,
`ifdef DCT_SER_TRUNC_ZEROS_EN
    output logic [IDX_W-1:0]               last_nz,
`endif
    output logic [N_COEF-1:0][DATA_W-1:0]  rd_data
);

`ifdef DCT_SER_TRUNC_ZEROS_EN
    logic [IDX_W-1:0] last_nz_next;

    // Highest nonzero index; an all-zero block reports 0 so coefficient 0
    // is still emitted.
    always_comb begin
        last_nz_next = '0;
        for (int k = 1; k < N_COEF; k++) begin
            if (wr_data[k] != '0) last_nz_next = IDX_W'(k);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     last_nz <= '0;
        else if (wr_en) last_nz <= last_nz_next;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
            full    <= 1'b0;
        end else begin
            if (wr_en) rd_data <= wr_data;
            // A bank is only written while empty and only released while
            // full, so the two events never hit the same bank at once.
            full <= wr_en | (full & ~rel);
        end
    end

endmodule

module dct_coef_serializer #(
    parameter int DATA_W = 12,
    parameter int N_COEF = 8,
    parameter int IDX_W  = $clog2(N_COEF)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N_COEF*DATA_W-1:0]  in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [IDX_W-1:0]          out_index,
    output logic                      out_last
);

    typedef logic [N_COEF-1:0][DATA_W-1:0] blk_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_COEF - 1);

    blk_t             in_blk;
    blk_t             bank_data [2];
    logic [1:0]       bank_full;
    logic             wr_ptr;
    logic             rd_ptr;
    logic [IDX_W-1:0] cnt;
    logic [IDX_W-1:0] end_idx;
    logic             cap;
    logic             out_fire;
    logic             at_end;
    logic             rel;

`ifdef DCT_SER_TRUNC_ZEROS_EN
    logic [IDX_W-1:0] bank_lnz [2];
`endif

    assign in_blk = in_data;

    // Banks fill and drain alternately, so whenever any bank is empty it
    // is the one under wr_ptr.
    assign in_ready  = ~&bank_full;
    assign cap       = in_valid & in_ready;
    assign out_valid = bank_full[rd_ptr];
    assign out_fire  = out_valid & out_ready;

`ifdef DCT_SER_TRUNC_ZEROS_EN
    assign end_idx = bank_lnz[rd_ptr];
`else
    assign end_idx = LAST_IDX;
`endif

    assign at_end = (cnt == end_idx);
    assign rel    = out_fire & at_end;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        dct_coef_bank #(
            .DATA_W (DATA_W),
            .N_COEF (N_COEF),
            .IDX_W  (IDX_W)
        ) u_bank (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (cap & (wr_ptr == 1'(b))),
            .rel     (rel & (rd_ptr == 1'(b))),
            .wr_data (in_blk),
            .full    (bank_full[b]),
`ifdef DCT_SER_TRUNC_ZEROS_EN
            .last_nz (bank_lnz[b]),
`endif
            .rd_data (bank_data[b])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= '0;
        end else begin
            if (cap) wr_ptr <= ~wr_ptr;
            if (out_fire) begin
                if (at_end) begin
                    cnt    <= '0;
                    rd_ptr <= ~rd_ptr;
                end else begin
                    cnt <= cnt + IDX_W'(1);
                end
            end
        end
    end

    // Outputs are driven from registered state only, so they hold under
    // backpressure. Data is forced to 0 while idle so stale bank contents
    // never leak onto the bus.
    assign out_data  = out_valid ? bank_data[rd_ptr][cnt] : '0;
    assign out_index = cnt;
    assign out_last  = out_valid & at_end;

endmodule

// File: doc/dct_coef_serializer.md
Name: dct_coef_serializer

Overview:
- Parameterised parallel-to-serial converter for DCT coefficient blocks.
- Accepts one block of N_COEF coefficients per handshake and streams them out one per cycle, in index order 0..N_COEF-1, toward the RLE encoder.
- Two-bank ping-pong storage: the next block can be captured while the current block streams.
- Valid/ready on both sides; end-of-block marker on output.

Parameters:
- DATA_W, 12, coefficient width in bits (signed two's complement; treated as opaque except for the zero test).
- N_COEF, 8, coefficients per block; legal range 2..64.
- IDX_W, $clog2(N_COEF), width of out_index; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream block present on in_data.
- in_ready  out  1  block capture possible this cycle.
- in_data  in  N_COEF*DATA_W  packed block; coefficient k at bits [k*DATA_W +: DATA_W].
- out_valid  out  1  out_data holds a valid coefficient.
- out_ready  in  1  downstream accepts the coefficient.
- out_data  out  DATA_W  current coefficient.
- out_index  out  IDX_W  position of out_data within its block.
- out_last  out  1  out_data is the final coefficient of the block.

Behaviour:
- Reset (async assert, sync-released use):
  - Both banks marked empty; bank contents cleared to 0.
  - Read and write bank pointers set to 0; coefficient counter set to 0.
  - in_ready=1 after reset release; out_valid=0, out_data=0, out_index=0, out_last=0.
- Reset mid-stream aborts the block in flight and discards both banks. No partial block is resumed.
- Capture:
  - Occurs when in_valid && in_ready.
  - Stores in_data into the write bank, marks it full, toggles the write pointer.
- in_ready=1 iff at least one bank is empty.
  - in_ready is a function of registered state only; there is no combinational path from out_ready or in_valid.
- Stream: out_valid=1 iff the read bank is full.
  - out_data = read_bank[counter]; out_index = counter.
- Output handshake: out_valid && out_ready advances the counter.
  - Final coefficient: out_last=1 when counter==N_COEF-1.
  - On its handshake: counter returns to 0, the read bank is marked empty, and the read pointer toggles.
- Backpressure: while out_valid && !out_ready, out_data, out_index and out_last stay stable.
- Latency and throughput:
  - A block captured at edge T presents coefficient 0 at edge T (out_valid=1 in cycle T+1) if no other block is pending.
  - Back-to-back blocks stream with zero bubbles between the last coefficient of one block and the first coefficient of the next.
- Simultaneous capture and final-coefficient release in the same cycle is legal only when in_ready was already 1. Both bank flags update independently.
  - With both banks full, the release frees a bank and in_ready rises the following cycle.
- Order: blocks are emitted strictly in capture order; no block is dropped or duplicated.
- Counter wrap: the counter never exceeds N_COEF-1, including for non-power-of-2 N_COEF.

Optional Feature:
- Macro: DCT_SER_TRUNC_ZEROS_EN.
- Defined:
  - At capture, compute last_nz = highest index with a nonzero coefficient (0 if the block is all zero) and store it per bank.
  - Streaming stops after index last_nz; out_last=1 at counter==last_nz.
  - Coefficient 0 is always emitted.
  - The trailing-zero run is implicit end-of-block for the RLE encoder.
- Not defined: every block emits exactly N_COEF coefficients. The last_nz logic and its storage are absent.

Test Plan:
- Reset, then one block 1..8 with out_ready=1 → out_data 1,2,...,8 on 8 consecutive cycles; out_index 0..7; out_last only with 8; then out_valid=0.
- Three blocks offered with in_valid held high, out_ready=1 → 24 coefficients with no gaps, in order. in_ready drops while both banks are full and rises one cycle after each final release.
- out_ready toggles 1,0,0,1 during a block → every value is held stable while stalled; no skipped or repeated coefficients; out_last still occurs on index 7.
- rst_n asserted after 3 of 8 coefficients, with a second block pending → outputs go to 0 immediately, in_ready=1 after release, and the next captured block starts at index 0.
- N_COEF=6, DATA_W=16 build; blocks 0x8000..0x8005 → wrap at index 5, no index 6/7 generated, sign bit preserved.
- With DCT_SER_TRUNC_ZEROS_EN:
  - Block 5,-3,0,2,0,0,0,0 → emits 5,-3,0,2 with out_last on 2.
  - All-zero block → a single 0 with out_last=1.
